vga_pattern_gen: RTL and testbench

Pixel source stage for the VGA path, directly downstream of the sync/pixel-counter timing block. It consumes the display enable, pixel coordinates and raw sync pulses, and drives registered 10-bit R/G/B to the ADV7123 with the sync pulses re-aligned to the colour data. Four selectable test patterns are provided, including a bouncing box animated once per frame. The pattern select is latched only at frame boundaries so that no frame tears.

---
 rtl/vga_pattern_gen_if.sv | 26 ++
 rtl/vga_pattern_gen.sv | 164 ++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream bundle between the VGA timing stage, the pattern generator and the DAC.
// The master side drives timing and pattern select; the slave side returns colour and re-aligned syncs.
interface vga_pattern_gen_if;
  logic [1:0]  mode;
  logic        disp_enable;
  logic [31:0] xpix;
  logic [31:0] ypix;
  logic        hsync_in;
  logic        vsync_in;
  logic [9:0]  r;
  logic [9:0]  g;
  logic [9:0]  b;
  logic        hsync_out;
  logic        vsync_out;
  logic        frame_tick;

  modport master (
    output mode, disp_enable, xpix, ypix, hsync_in, vsync_in,
    input  r, g, b, hsync_out, vsync_out, frame_tick
  );

  modport slave (
    input  mode, disp_enable, xpix, ypix, hsync_in, vsync_in,
    output r, g, b, hsync_out, vsync_out, frame_tick
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern source for the ADV7123 path: four patterns, two-stage pipeline, syncs kept aligned
// with colour, pattern select and bouncing-box position updated only at frame boundaries.
module vga_pattern_gen #(
  parameter int   H_DISP   = 1280,
  parameter int   V_DISP   = 1024,
  parameter int   BOX      = 64,
  parameter int   STEP     = 4,
  parameter logic SYNC_ACT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_pattern_gen_if.slave bus
);

  localparam logic [9:0] F     = 10'h3FF;
  localparam int         BAR_W = H_DISP / 8;

  logic        de1_reg, hs1_reg, vs1_reg;
  logic [10:0] x1_reg, y1_reg;
  logic [9:0]  r_reg, g_reg, b_reg;
  logic [9:0]  r_next, g_next, b_next;
  logic        hs2_reg, vs2_reg;
  logic        frame_tick_reg;
  logic [1:0]  mode_reg;
  logic [10:0] bx, by;
  logic [6:0]  bar_ge;
  logic [2:0]  bar_idx;
  logic        blank, in_box;
  logic        unused_hi;

  assign unused_hi = &{bus.xpix[31:11], bus.ypix[31:11]};

  // Stage 1; vs1_reg doubles as the vsync history for frame-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de1_reg <= 1'b0;
      x1_reg  <= '0;
      y1_reg  <= '0;
      hs1_reg <= ~SYNC_ACT;
      vs1_reg <= ~SYNC_ACT;
    end else begin
      de1_reg <= bus.disp_enable;
      x1_reg  <= bus.xpix[10:0];
      y1_reg  <= bus.ypix[10:0];
      hs1_reg <= bus.hsync_in;
      vs1_reg <= bus.vsync_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick_reg <= 1'b0;
      mode_reg       <= 2'd0;
    end else begin
      frame_tick_reg <= (bus.vsync_in == SYNC_ACT) && (vs1_reg != SYNC_ACT);
      if (frame_tick_reg) begin
        mode_reg <= bus.mode;
      end
    end
  end

  // Box position per axis: bounces between 0 and DISP-BOX, clamping at the walls.
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    localparam logic [11:0] LIM = (gi == 0) ? 12'(H_DISP - BOX) : 12'(V_DISP - BOX);
    logic [10:0] pos_reg;
    logic        dir_reg;
    logic [11:0] pos_ext;

    assign pos_ext = {1'b0, pos_reg};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pos_reg <= '0;
        dir_reg <= 1'b1;
      end else if (frame_tick_reg) begin
        if (dir_reg) begin
          if (pos_ext + 12'(STEP) >= LIM) begin
            pos_reg <= LIM[10:0];
            dir_reg <= 1'b0;
          end else begin
            pos_reg <= 11'(pos_ext + 12'(STEP));
          end
        end else if (pos_ext <= 12'(STEP)) begin
          pos_reg <= '0;
          dir_reg <= 1'b1;
        end else begin
          pos_reg <= 11'(pos_ext - 12'(STEP));
        end
      end
    end
  end

  assign bx = g_axis[0].pos_reg;
  assign by = g_axis[1].pos_reg;

  for (genvar gi = 0; gi < 7; gi++) begin : g_bar
    assign bar_ge[gi] = (x1_reg >= 11'((gi + 1) * BAR_W));
  end

  // bar_ge is a thermometer code, so its population count is the bar index.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      bar_idx = bar_idx + {2'b00, bar_ge[i]};
    end
  end

  assign blank  = !de1_reg || (x1_reg >= 11'(H_DISP)) || (y1_reg >= 11'(V_DISP));
  assign in_box = ({1'b0, x1_reg} >= {1'b0, bx}) && ({1'b0, x1_reg} < {1'b0, bx} + 12'(BOX)) &&
                  ({1'b0, y1_reg} >= {1'b0, by}) && ({1'b0, y1_reg} < {1'b0, by} + 12'(BOX));

  always_comb begin
    r_next = '0;
    g_next = '0;
    b_next = '0;
    if (!blank) begin
      case (mode_reg)
        2'd0: begin
          r_next = bar_idx[1] ? 10'h0 : F;
          g_next = bar_idx[2] ? 10'h0 : F;
          b_next = bar_idx[0] ? 10'h0 : F;
        end
        2'd1: begin
          r_next = (x1_reg[5] ^ y1_reg[5]) ? F : 10'h0;
          g_next = r_next;
          b_next = r_next;
        end
        2'd2: begin
          r_next = in_box ? F : 10'h0;
          g_next = r_next;
          b_next = F;
        end
        default: begin
          r_next = x1_reg[9:0];
          g_next = y1_reg[9:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg   <= '0;
      g_reg   <= '0;
      b_reg   <= '0;
      hs2_reg <= ~SYNC_ACT;
      vs2_reg <= ~SYNC_ACT;
    end else begin
      r_reg   <= r_next;
      g_reg   <= g_next;
      b_reg   <= b_next;
      hs2_reg <= hs1_reg;
      vs2_reg <= vs1_reg;
    end
  end

  assign bus.r          = r_reg;
  assign bus.g          = g_reg;
  assign bus.b          = b_reg;
  assign bus.hsync_out  = hs2_reg;
  assign bus.vsync_out  = vs2_reg;
  assign bus.frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed and random pixel streams scored against a frame-level model.
module tb_vga_pattern_gen;

  localparam logic [9:0] F = 10'h3FF;
  localparam logic [9:0] Z = 10'h000;

  typedef struct packed {
    logic [29:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_pattern_gen_if bus ();

  vga_pattern_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  exp_t  exp_q[$];
  logic  prev_vs   = 1'b0;
  logic  last_edge = 1'b0;
  int    frame_n   = 0;
  int    mode_use  = 0;
  string ctx       = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0h expected %0h", ctx, tag, got, exp);
    end
  endtask

  // Box travel is a triangle wave of period 2*lim in steps of 4 px per frame.
  function automatic int tri_pos(input int n, input int lim);
    int p;
    p = (4 * n) % (2 * lim);
    return (p > lim) ? 2 * lim - p : p;
  endfunction

  function automatic logic [29:0] model_rgb(input int md, input logic de, input int x, input int y,
                                            input int n);
    int bx, by;
    bx = tri_pos(n, 1216);
    by = tri_pos(n, 960);
    if (!de || x >= 1280 || y >= 1024) return {Z, Z, Z};
    case (md)
      0: case (x / 160)
           0: return {F, F, F};
           1: return {F, F, Z};
           2: return {Z, F, F};
           3: return {Z, F, Z};
           4: return {F, Z, F};
           5: return {F, Z, Z};
           6: return {Z, Z, F};
           default: return {Z, Z, Z};
         endcase
      1: return ((((x / 32) + (y / 32)) % 2) == 1) ? {F, F, F} : {Z, Z, Z};
      2: return (x >= bx && x < bx + 64 && y >= by && y < by + 64) ? {F, F, F} : {Z, Z, F};
      default: return {10'(x % 1024), 10'(y % 1024), Z};
    endcase
  endfunction

  task automatic sample();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rgb", {2'b00, bus.r, bus.g, bus.b}, {2'b00, e.rgb});
      check("hsync_out", {31'd0, bus.hsync_out}, {31'd0, e.hs});
      check("vsync_out", {31'd0, bus.vsync_out}, {31'd0, e.vs});
    end
    check("frame_tick", {31'd0, bus.frame_tick}, {31'd0, last_edge});
  endtask

  // One pixel clock: score the outputs, drive the next inputs, then advance to the next falling edge.
  task automatic step(input logic de, input int x, input int y, input logic hs, input logic vs);
    logic [31:0] rx, ry;
    logic        edge_now;
    exp_t        e;
    sample();
    edge_now = vs && !prev_vs;
    prev_vs  = vs;
    if (edge_now) begin
      frame_n++;
      mode_use = int'(bus.mode);
    end
    rx = $urandom();
    ry = $urandom();
    bus.disp_enable = de;
    bus.xpix        = {rx[31:11], 11'(x)};
    bus.ypix        = {ry[31:11], 11'(y)};
    bus.hsync_in    = hs;
    bus.vsync_in    = vs;
    e.rgb = model_rgb(mode_use, de, x % 2048, y % 2048, frame_n);
    e.hs  = hs;
    e.vs  = vs;
    exp_q.push_back(e);
    last_edge = edge_now;
    @(negedge clk);
  endtask

  task automatic pix(input int x, input int y);
    step(1'b1, x, y, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic frame_sync();
    repeat (3) step(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    exp_t z;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_rgb", {2'b00, bus.r, bus.g, bus.b}, 32'd0);
    check("rst_hsync", {31'd0, bus.hsync_out}, 32'd0);
    check("rst_vsync", {31'd0, bus.vsync_out}, 32'd0);
    check("rst_tick", {31'd0, bus.frame_tick}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    z = '0;
    exp_q.push_back(z);
    exp_q.push_back(z);
    prev_vs   = 1'b0;
    last_edge = 1'b0;
    frame_n   = 0;
    mode_use  = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bx, by;
    bus.mode = 2'd0;
    bus.disp_enable = 1'b0;
    bus.xpix = '0;
    bus.ypix = '0;
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;

    do_reset();
    ctx = "pre";
    repeat (4) step(1'b1, 0, 0, 1'b1, 1'b0);

    // Reset mid-line with live white pixels; mode 3 requested but first frame must be bars.
    ctx = "reset_mid";
    bus.mode = 2'd3;
    do_reset();
    ctx = "bars";
    step(1'b1, 0, 0, 1'b0, 1'b0);
    pix(159, 3);
    pix(160, 3);
    pix(1279, 3);
    pix(1280, 3);
    repeat (20) pix($urandom_range(0, 1400), $urandom_range(0, 1100));

    ctx = "mode1";
    bus.mode = 2'd1;
    frame_sync();
    pix(32, 0);
    pix(32, 32);
    repeat (20) pix($urandom_range(0, 1400), $urandom_range(0, 1100));

    ctx = "edge_after_reset";
    do_reset();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0);

    // Bouncing box: probe just inside and just outside each box edge every frame.
    ctx = "box";
    do_reset();
    bus.mode = 2'd2;
    for (int f = 0; f < 310; f++) begin
      frame_sync();
      bx = tri_pos(frame_n, 1216);
      by = tri_pos(frame_n, 960);
      pix(bx, by);
      pix(bx + 63, by + 63);
      pix(bx + 64, by);
      pix(bx, by + 64);
      if (bx > 0) pix(bx - 1, by);
      if (by > 0) pix(bx, by - 1);
    end

    ctx = "mode0to3";
    bus.mode = 2'd0;
    frame_sync();
    pix(200, 10);
    bus.mode = 2'd3;
    pix(200, 10);
    pix(500, 20);
    pix(5, 7);
    frame_sync();
    pix(5, 7);
    pix(1023, 1000);

    ctx = "blank3";
    step(1'b0, 100, 50, 1'b1, 1'b0);
    step(1'b0, 100, 50, 1'b0, 1'b0);
    step(1'b0, 100, 50, 1'b1, 1'b0);

    ctx = "random";
    for (int f = 0; f < 40; f++) begin
      bus.mode = 2'($urandom_range(0, 3));
      repeat (25) step(1'($urandom_range(0, 7) != 0), $urandom_range(0, 1400),
                       $urandom_range(0, 1100), 1'($urandom_range(0, 1)), 1'b0);
      frame_sync();
    end

    ctx = "drain";
    repeat (2) step(1'b0, 0, 0, 1'b0, 1'b0);
    sample();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
